// File: rtl/clock_divide_monitor_if.sv
// clock_divide_monitor_if
//   Groups the measurement controls and results of clock_divide_monitor.
//   Parameter CNT_W: width of period/high-time values (default 8).
//   master: drives enable, div_in, exp_period, exp_high, clr_err and
//           observes the measurement results and flags.
//   slave : the monitor itself; sees the controls, drives period,
//           high_time, meas_valid, locked, err_period, err_high, err_stuck.
interface clock_divide_monitor_if #(
  parameter int CNT_W = 8
);
  logic             enable;
  logic             div_in;
  logic [CNT_W-1:0] exp_period;
  logic [CNT_W-1:0] exp_high;
  logic             clr_err;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_high;
  logic             err_stuck;

  modport master (
    output enable, div_in, exp_period, exp_high, clr_err,
    input  period, high_time, meas_valid, locked,
           err_period, err_high, err_stuck
  );

  modport slave (
    input  enable, div_in, exp_period, exp_high, clr_err,
    output period, high_time, meas_valid, locked,
           err_period, err_high, err_stuck
  );
endinterface

// File: rtl/clock_divide_monitor.sv
// clock_divide_monitor
//   Samples a divided clock (div_in) as data on clkin, measures each period
//   and high time in clkin cycles, compares them with exp_period/exp_high,
//   and reports lock plus sticky period/high/stuck error flags.
// Parameters:
//   CNT_W    : counter and expected-value width (default 8)
//   LOCK_CNT : consecutive matching periods needed for locked (1..15)
// Ports:
//   clkin : fast clock, rising edge
//   reset : asynchronous, active-low
//   mon   : clock_divide_monitor_if.slave (controls in, results/flags out)
// Build option:
//   CLKMON_SYNC_EN : inserts two synchronizer flops ahead of the sample
//                    register (latency 2 -> 4 edges, values unchanged).
module clock_divide_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic                   clkin,
  input  logic                   reset,
  clock_divide_monitor_if.slave  mon
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_MAX  = 4'(LOCK_CNT);
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);

  state_t           state;
  logic             s1;
  logic             s1_d;
  logic             s1_src;
  logic             rise;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [3:0]       match_cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_high;
  logic             err_stuck;

`ifdef CLKMON_SYNC_EN
  logic sync0;
  logic sync1;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= mon.div_in;
      sync1 <= sync0;
    end
  end

  assign s1_src = sync1;
`else
  assign s1_src = mon.div_in;
`endif

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s1_d <= 1'b0;
    end else begin
      s1   <= s1_src;
      s1_d <= s1;
    end
  end

  assign rise = s1 & ~s1_d;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      hcnt       <= '0;
      match_cnt  <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err_period <= 1'b0;
      err_high   <= 1'b0;
      err_stuck  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // Clear first so that an error event later in this block overrides it.
      if (mon.clr_err) begin
        err_period <= 1'b0;
        err_high   <= 1'b0;
        err_stuck  <= 1'b0;
      end
      if (!mon.enable) begin
        state     <= IDLE;
        pcnt      <= '0;
        hcnt      <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
          end
          ARM: begin
            // The period in flight when arming is partial; start at a rise.
            if (rise) begin
              pcnt      <= ONE;
              hcnt      <= ONE;
              match_cnt <= '0;
              state     <= MEAS;
            end
          end
          MEAS: begin
            if (rise) begin
              period     <= pcnt;
              high_time  <= hcnt;
              meas_valid <= 1'b1;
              pcnt       <= ONE;
              hcnt       <= ONE;
              if (pcnt == mon.exp_period && hcnt == mon.exp_high) begin
                if (match_cnt < LOCK_MAX) match_cnt <= match_cnt + 4'd1;
                if (match_cnt >= LOCK_LAST) locked <= 1'b1;
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
                if (pcnt != mon.exp_period) err_period <= 1'b1;
                if (hcnt != mon.exp_high)   err_high   <= 1'b1;
              end
            end else if (pcnt == '1) begin
              // Counter is full with no rise: declare the input stuck
              // rather than wrapping, and rearm on the next rise.
              err_stuck <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              pcnt      <= '0;
              hcnt      <= '0;
              state     <= ARM;
            end else begin
              pcnt <= pcnt + ONE;
              hcnt <= hcnt + {{(CNT_W-1){1'b0}}, s1};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon.period     = period;
  assign mon.high_time  = high_time;
  assign mon.meas_valid = meas_valid;
  assign mon.locked     = locked;
  assign mon.err_period = err_period;
  assign mon.err_high   = err_high;
  assign mon.err_stuck  = err_stuck;

endmodule

// File: doc/clock_divide_monitor.md
# clock_divide_monitor

Checker stage for the divided clocks produced by the clock dividers. It samples a divided clock on the fast clock as a data signal and measures each period and high time in fast-clock cycles. It compares both against programmable expected values and reports a lock indication plus sticky error flags. Integration uses it as a self-check of a divider output, for example a divide-by-3 (period 3) feeding `div_in`.

## Interface
- `CNT_W`, 8: width of period and high-time counters and expected-value inputs.
- `LOCK_CNT`, 4: consecutive matching periods required to assert `locked`; legal range 1..15.
- `clkin`  input  1  fast clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `enable`  input  1  measurement enable; level-sensitive.
- `div_in`  input  1  divided clock under test, treated as data.
- `exp_period`  input  CNT_W  expected period in clkin cycles; must be ≥2.
- `exp_high`  input  CNT_W  expected high time in clkin cycles.
- `clr_err`  input  1  one-cycle pulse that clears all sticky error flags.
- `period`  output  CNT_W  last measured period.
- `high_time`  output  CNT_W  last measured high time.
- `meas_valid`  output  1  one-cycle pulse when `period`/`high_time` update.
- `locked`  output  1  LOCK_CNT consecutive periods matched both expectations.
- `err_period`, `err_high`, `err_stuck`  output  1 each  sticky error flags.

## Operation
- Input path: `div_in` → sample register `s1` → delay register `s1_d`. Rise detect is `s1 & ~s1_d`.
- FSM states:
  - IDLE: counters held at 0.
    - `enable`=1 → ARM.
  - ARM: waits for the first rise and discards the partial period.
    - On rise: `pcnt`←1, `hcnt`←1, match count←0 → MEAS.
  - MEAS: every non-rise cycle, `pcnt`+1 and `hcnt`+`s1`.
    - On rise: capture `period`←`pcnt` and `high_time`←`hcnt`. Pulse `meas_valid`. Compare both captured values with the expected inputs. Then restart at `pcnt`←1, `hcnt`←1.
- Compare outcome:
  - Both values match: the match count increments, saturating at LOCK_CNT. `locked` is set when the count reaches LOCK_CNT.
  - Either value mismatches: the match count clears and `locked` clears. `err_period` and/or `err_high` set, matching the field that failed.
- Timeout: in MEAS, if `pcnt` reaches 2^CNT_W−1 with no rise, then `err_stuck` sets, `locked` clears, and the FSM goes to ARM. Counters never wrap.
- `enable`=0 in any state: next cycle IDLE, `locked`=0, counters and match count clear. `period`, `high_time` and the error flags hold their values.
- `clr_err` clears all three flags. If an error event occurs in the same cycle as `clr_err`, the event wins and its flag stays set.
- `exp_*` are sampled at compare time. A change mid-period applies at the next rise.

## Timing
- Reset values: `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, all error flags=0, FSM=IDLE, `s1`/`s1_d`=0.
- `div_in` first sampled high at edge k: the rise is detected during cycle k→k+1. `meas_valid`, `period` and `high_time` update at edge k+1. Latency is 2 edges; each additional synchronizer stage adds 1.
- The lock, error and timeout flags update on the same edge as `meas_valid`.
- Reset asserted mid-measurement forces all reset values immediately, independent of `clkin`.
- Back-to-back rises spaced 2 cycles apart are legal and give `period`=2.

## Configuration
- `CLKMON_SYNC_EN`: when defined, two synchronizer flops are inserted before `s1`. Latency becomes 4 edges and measured values are unchanged.
- When not defined, `div_in` is assumed synchronous to `clkin` and latency is 2.

## Test plan
- Divide-by-3 input, high 1 cycle in every 3, `exp_period`=3, `exp_high`=1, `LOCK_CNT`=4 → `meas_valid` every 3 cycles. `period`=3 and `high_time`=1. `locked`=1 at the 4th `meas_valid`; no errors.
- Same input with `exp_high`=2 → `err_high`=1 and `locked`=0 at the first compare. `clr_err` clears the flag; it re-sets at the next `meas_valid`.
- One period stretched to 5 cycles while locked → `period`=5, `err_period`=1, `locked`=0. Lock returns after 4 further good periods.
- `div_in` held at 0, `CNT_W`=4 → `err_stuck`=1 when `pcnt` reaches 15; FSM returns to ARM. Restarting the input gives a first `meas_valid` only after two rises.
- `enable` dropped mid-period → `locked`=0 next cycle, no `meas_valid`, `period` retained. Re-enabling discards the first partial period.
- `reset` pulsed low mid-period → all outputs 0 immediately. Build with `CLKMON_SYNC_EN` → the same sequence with `meas_valid` delayed 2 extra cycles.
